// File: rtl/spi_frame_decoder.sv
// SPI frame decoder: turns a command byte plus data bytes into register write/read strobes.
// Optional macro SPI_FRAME_BURST_INC_EN enables burst writes with auto-incrementing address.
module spi_frame_decoder #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DATA_BYTES = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_ss,
    input  logic                      i_byte_valid,
    input  logic [7:0]                i_byte_data,
    output logic                      o_wr_en,
    output logic [ADDR_W-1:0]         o_wr_addr,
    output logic [8*DATA_BYTES-1:0]   o_wr_data,
    output logic                      o_rd_req,
    output logic [ADDR_W-1:0]         o_rd_addr,
    output logic                      o_frame_err,
    output logic                      o_busy
);

    localparam int unsigned DW = 8 * DATA_BYTES;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {StIdle, StCmd, StData, StDrain} state_e;

    state_e              r_state;
    logic [CW-1:0]       r_cnt;
    logic [DW-1:0]       r_shift;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_is_write;
    logic                r_excess;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DW-1:0]       r_wr_data;
    logic                r_rd_req;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_frame_err;
    logic                r_busy;

    logic [DW-1:0]       w_shift_nxt;
    logic [CW-1:0]       w_cnt_inc;
    logic                w_word_done;
    logic                w_err;

    assign w_shift_nxt = DW'({r_shift, i_byte_data});
    assign w_cnt_inc   = r_cnt + CW'(1);
    assign w_word_done = (w_cnt_inc == CW'(DATA_BYTES));

    // Error verdict for a frame ending this cycle, after any same-cycle byte is accounted for.
    always_comb begin
        w_err = 1'b0;
        unique case (r_state)
            StCmd:   w_err = !i_byte_valid;
            StData:  w_err = i_byte_valid ? !w_word_done : (r_cnt != '0);
            StDrain: w_err = r_excess | (i_byte_valid & r_is_write);
            default: w_err = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_addr      <= '0;
            r_is_write  <= 1'b0;
            r_excess    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rd_req    <= 1'b0;
            r_rd_addr   <= '0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_wr_en     <= 1'b0;
            r_rd_req    <= 1'b0;
            r_frame_err <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (!i_ss) begin
                        r_state    <= StCmd;
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                        r_excess   <= 1'b0;
                        r_is_write <= 1'b0;
                    end
                end
                StCmd: begin
                    if (i_byte_valid) begin
                        if (i_byte_data[7]) begin
                            r_is_write <= 1'b1;
                            r_addr     <= i_byte_data[ADDR_W-1:0];
                            r_state    <= StData;
                        end else begin
                            r_rd_req  <= 1'b1;
                            r_rd_addr <= i_byte_data[ADDR_W-1:0];
                            r_state   <= StDrain;
                        end
                    end
                end
                StData: begin
                    if (i_byte_valid) begin
                        r_shift <= w_shift_nxt;
                        if (w_word_done) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_addr;
                            r_wr_data <= w_shift_nxt;
                            r_cnt     <= '0;
`ifdef SPI_FRAME_BURST_INC_EN
                            r_addr    <= r_addr + ADDR_W'(1);
`else
                            r_state   <= StDrain;
`endif
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                StDrain: begin
                    if (i_byte_valid && r_is_write) begin
                        r_excess <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase

            // Frame end overrides the state update above; a same-cycle byte was still consumed.
            if (r_state != StIdle && i_ss) begin
                r_state     <= StIdle;
                r_busy      <= 1'b0;
                r_frame_err <= w_err;
                r_cnt       <= '0;
                r_excess    <= 1'b0;
            end
        end
    end

    assign o_wr_en     = r_wr_en;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_rd_req    = r_rd_req;
    assign o_rd_addr   = r_rd_addr;
    assign o_frame_err = r_frame_err;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Directed self-checking bench for spi_frame_decoder (default parameters).
// Burst expectations follow SPI_FRAME_BURST_INC_EN when it is defined.
module tb_spi_frame_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ss = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_req;
    logic [6:0]  rd_addr;
    logic        frame_err;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;
    int n_wr    = 0;
    int n_rd    = 0;
    int n_err   = 0;
    int b_wr, b_rd, b_err;

    spi_frame_decoder dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ss         (ss),
        .i_byte_valid (byte_valid),
        .i_byte_data  (byte_data),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_rd_req     (rd_req),
        .o_rd_addr    (rd_addr),
        .o_frame_err  (frame_err),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    // Strobe-cycle counters; a stuck strobe shows up as an extra count.
    always @(negedge clk) begin
        if (wr_en)     n_wr++;
        if (rd_req)    n_rd++;
        if (frame_err) n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick(1);
        byte_valid = 1'b0;
    endtask

    task automatic start_frame();
        b_wr = n_wr; b_rd = n_rd; b_err = n_err;
        ss = 1'b0;
        tick(2);
    endtask

    task automatic end_frame();
        ss = 1'b1;
        tick(1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'h0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'h0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'h0);
        chk({tag, "_rd_req"}, 32'(rd_req), 32'h0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'h0);
        chk({tag, "_err"}, 32'(frame_err), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        tick(2);
        chk_zero_outputs("rst");
        rst = 1'b0;
        tick(2);

        // Single write
        start_frame();
        chk("wr_busy", 32'(busy), 32'h1);
        send_byte(8'h85); tick(1);
        send_byte(8'hAB); tick(1);
        send_byte(8'hCD);
        chk("wr_en", 32'(wr_en), 32'h1);
        chk("wr_addr", 32'(wr_addr), 32'h05);
        chk("wr_data", 32'(wr_data), 32'hABCD);
        tick(1);
        chk("wr_en_low", 32'(wr_en), 32'h0);
        end_frame();
        chk("wr_err", 32'(frame_err), 32'h0);
        chk("wr_busy_end", 32'(busy), 32'h0);
        tick(2);
        chk("wr_count", 32'(n_wr - b_wr), 32'h1);
        chk("wr_err_count", 32'(n_err - b_err), 32'h0);

        // Read with a trailing byte, which is not an error
        start_frame();
        send_byte(8'h12);
        chk("rd_req", 32'(rd_req), 32'h1);
        chk("rd_addr", 32'(rd_addr), 32'h12);
        tick(1);
        chk("rd_req_low", 32'(rd_req), 32'h0);
        send_byte(8'h99); tick(1);
        end_frame();
        chk("rd_err", 32'(frame_err), 32'h0);
        tick(2);
        chk("rd_count", 32'(n_rd - b_rd), 32'h1);
        chk("rd_no_wr", 32'(n_wr - b_wr), 32'h0);

        // Partial word
        start_frame();
        send_byte(8'h83); tick(1);
        send_byte(8'h11); tick(1);
        chk("part_err_early", 32'(frame_err), 32'h0);
        end_frame();
        chk("part_err", 32'(frame_err), 32'h1);
        tick(1);
        chk("part_err_low", 32'(frame_err), 32'h0);
        tick(1);
        chk("part_no_wr", 32'(n_wr - b_wr), 32'h0);

        // Burst / excess bytes
        start_frame();
        send_byte(8'hFF); tick(1);
        send_byte(8'h01); tick(1);
        send_byte(8'h02);
        chk("bst_en1", 32'(wr_en), 32'h1);
        chk("bst_addr1", 32'(wr_addr), 32'h7F);
        chk("bst_data1", 32'(wr_data), 32'h0102);
        tick(1);
        send_byte(8'h03); tick(1);
        send_byte(8'h04);
`ifdef SPI_FRAME_BURST_INC_EN
        chk("bst_en2", 32'(wr_en), 32'h1);
        chk("bst_addr2", 32'(wr_addr), 32'h00);
        chk("bst_data2", 32'(wr_data), 32'h0304);
        tick(1);
        end_frame();
        chk("bst_err", 32'(frame_err), 32'h0);
        tick(2);
        chk("bst_count", 32'(n_wr - b_wr), 32'h2);
`else
        chk("bst_en2", 32'(wr_en), 32'h0);
        tick(1);
        end_frame();
        chk("bst_err", 32'(frame_err), 32'h1);
        tick(2);
        chk("bst_count", 32'(n_wr - b_wr), 32'h1);
`endif

        // Reset mid-frame, then a fresh write frame
        start_frame();
        send_byte(8'h85); tick(1);
        send_byte(8'hAB);
        rst = 1'b1;
        #1;
        chk_zero_outputs("mrst");
        tick(2);
        ss  = 1'b1;
        rst = 1'b0;
        tick(3);
        chk("mrst_no_wr", 32'(n_wr - b_wr), 32'h0);
        chk("mrst_no_err", 32'(n_err - b_err), 32'h0);
        start_frame();
        send_byte(8'h82); tick(1);
        send_byte(8'h55); tick(1);
        send_byte(8'h66);
        chk("mrst_en", 32'(wr_en), 32'h1);
        chk("mrst_addr", 32'(wr_addr), 32'h02);
        chk("mrst_data", 32'(wr_data), 32'h5566);
        tick(1);
        end_frame();
        chk("mrst_err", 32'(frame_err), 32'h0);
        tick(2);
        chk("mrst_count", 32'(n_wr - b_wr), 32'h1);

        // Empty frame
        start_frame();
        tick(10);
        chk("empty_busy", 32'(busy), 32'h1);
        end_frame();
        chk("empty_err", 32'(frame_err), 32'h1);
        chk("empty_busy_end", 32'(busy), 32'h0);
        tick(1);
        chk("empty_err_low", 32'(frame_err), 32'h0);
        chk("empty_busy_low", 32'(busy), 32'h0);
        tick(1);
        chk("empty_err_count", 32'(n_err - b_err), 32'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
